// File: rtl/mar_seq.sv
// Memory address register with wrap-around post-increment and a single-outstanding
// read/write sequencer toward memory, bounded by a ready timeout.
module mar_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned VAL     = 0,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned STRIDE  = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] dIn,
    input  logic              Rin,
    input  logic              inc,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              auto_inc,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] address,
    output logic              mem_en,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              tout,
    output logic              err
);
    localparam int unsigned SUM_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] address_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              we_nx, ainc, ainc_nx, tout_nx, err_nx;
    logic [SUM_W-1:0]  step_raw;
    logic [ADDR_W-1:0] step_addr;
    logic              unused_din;

    assign unused_din = ^dIn;

    // Post-increment with a single wrap subtraction, shared by inc and auto-increment
    assign step_raw  = SUM_W'(address) + SUM_W'(STRIDE);
    assign step_addr = (step_raw >= SUM_W'(DEPTH)) ? ADDR_W'(step_raw - SUM_W'(DEPTH))
                                                   : ADDR_W'(step_raw);

    // Next-state and register updates
    always_comb begin
        state_nx   = state;
        address_nx = address;
        cnt_nx     = cnt;
        we_nx      = mem_we;
        ainc_nx    = ainc;
        tout_nx    = tout;
        err_nx     = err;
        unique case (state)
            IDLE: begin
                if (Rin) begin
                    address_nx = dIn[ADDR_W-1:0];
                    err_nx     = ({1'b0, dIn[ADDR_W-1:0]} >= SUM_W'(DEPTH));
                end else if (inc) begin
                    address_nx = step_addr;
                end else if ((rd_req || wr_req) && !err) begin
                    state_nx = ACCESS;
                    we_nx    = wr_req;
                    ainc_nx  = auto_inc;
                    cnt_nx   = '0;
                    tout_nx  = 1'b0;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_nx = DONE;
                    we_nx    = 1'b0;
                    tout_nx  = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = DONE;
                    we_nx    = 1'b0;
                    tout_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (!tout && ainc) begin
                    address_nx = step_addr;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; status flags are decoded from the next state
    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= IDLE;
            address <= ADDR_W'(VAL);
            cnt     <= '0;
            mem_we  <= 1'b0;
            ainc    <= 1'b0;
            tout    <= 1'b0;
            err     <= 1'b0;
            mem_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            address <= address_nx;
            cnt     <= cnt_nx;
            mem_we  <= we_nx;
            ainc    <= ainc_nx;
            tout    <= tout_nx;
            err     <= err_nx;
            mem_en  <= (state_nx == ACCESS);
            busy    <= (state_nx != IDLE);
            done    <= (state_nx == DONE);
        end
    end
endmodule
